// File: rtl/arb_pkg.sv
// Shared types for the unified memory arbiter: FSM states and requester ids.
package arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY_I,
        ARB_BUSY_D
    } arb_state_e;

    typedef enum logic {
        ARB_SRC_IF,
        ARB_SRC_D
    } arb_src_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of data grants made while a fetch waits; at_max forces
// the next contended grant to the fetch side.
module arb_starve_ctr #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);
    localparam int W = $clog2(MAX + 1);

    logic [W-1:0] starve_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (clr) begin
            starve_cnt <= '0;
        end else if (inc && (starve_cnt != W'(MAX))) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign at_max = (starve_cnt == W'(MAX));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access.
// Data wins by default; define ARB_STARVE_GUARD_EN to bound fetch starvation.
//
// state      | meaning
// ARB_IDLE   | nothing outstanding; arbitrate at the clock edge
// ARB_BUSY_I | fetch access outstanding, waiting for mem_rvalid
// ARB_BUSY_D | data access outstanding, waiting for mem_rvalid
module unified_mem_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_valid,
    output logic                if_stall,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_valid,
    output logic                d_stall,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_rvalid
);
    arb_state_e state_q, state_d;
    logic       grant;
    arb_src_e   grant_src;
    logic       force_if;

`ifdef ARB_STARVE_GUARD_EN
    logic starve_inc, starve_clr;

    assign starve_inc = grant && (grant_src == ARB_SRC_D) && if_req;
    assign starve_clr = grant && (grant_src == ARB_SRC_IF);

    arb_starve_ctr #(.MAX(STARVE_MAX)) u_starve_ctr (
        .clk    (clk),
        .rst    (rst),
        .inc    (starve_inc),
        .clr    (starve_clr),
        .at_max (force_if)
    );
`else
    logic unused_starve_max;
    assign unused_starve_max = (STARVE_MAX > 0);
    assign force_if          = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        grant     = 1'b0;
        grant_src = ARB_SRC_D;
        if_valid  = 1'b0;
        d_valid   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (d_req && !(if_req && force_if)) begin
                    grant     = 1'b1;
                    grant_src = ARB_SRC_D;
                    state_d   = ARB_BUSY_D;
                end else if (if_req) begin
                    grant     = 1'b1;
                    grant_src = ARB_SRC_IF;
                    state_d   = ARB_BUSY_I;
                end
            end
            ARB_BUSY_I: begin
                if (mem_rvalid) begin
                    if_valid = 1'b1;
                    state_d  = ARB_IDLE;
                end
            end
            ARB_BUSY_D: begin
                if (mem_rvalid) begin
                    d_valid = 1'b1;
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request fields are latched at grant so requester changes while busy are ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else if (grant) begin
            mem_req <= 1'b1;
            if (grant_src == ARB_SRC_D) begin
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                mem_be    <= d_be;
            end else begin
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
                mem_be    <= '1;
            end
        end else if ((state_q != ARB_IDLE) && mem_rvalid) begin
            mem_req <= 1'b0;
        end
    end

    assign if_rdata = mem_rdata;
    assign d_rdata  = mem_rdata;
    assign if_stall = if_req & ~if_valid;
    assign d_stall  = d_req & ~d_valid;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: transaction-level model plus directed scenarios.
module tb_unified_mem_arbiter;
    localparam int SMAX = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_valid, if_stall;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_be = '0;
    logic [31:0] d_rdata;
    logic        d_valid, d_stall;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata = '0;
    logic        mem_rvalid = 1'b0;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_valid(if_valid), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: one outstanding transaction record, granted by priority rules.
    bit          m_busy = 1'b0;
    bit          m_is_d = 1'b0;
    bit          m_we = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [3:0]  m_be = '0;
    int          m_starve = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy   = 1'b0;
            m_starve = 0;
        end else if (!m_busy) begin
            if (d_req && !(GUARD && if_req && m_starve == SMAX)) begin
                m_busy = 1'b1; m_is_d = 1'b1; m_we = d_we;
                m_addr = d_addr; m_wdata = d_wdata; m_be = d_be;
                if (if_req && m_starve < SMAX) m_starve++;
            end else if (if_req) begin
                m_busy = 1'b1; m_is_d = 1'b0; m_we = 1'b0;
                m_addr = if_addr; m_wdata = '0; m_be = 4'hF;
                m_starve = 0;
            end
        end else if (mem_rvalid) begin
            m_busy = 1'b0;
        end
    end

    always @(negedge clk) begin : compare
        bit ev_if, ev_d;
        ev_if = m_busy && !m_is_d && mem_rvalid;
        ev_d  = m_busy && m_is_d && mem_rvalid;
        chk("mdl_mem_req", mem_req, 32'(m_busy));
        if (m_busy) begin
            chk("mdl_mem_we", mem_we, 32'(m_we));
            chk("mdl_mem_addr", mem_addr, m_addr);
            chk("mdl_mem_wdata", mem_wdata, m_wdata);
            chk("mdl_mem_be", mem_be, m_be);
        end
        chk("mdl_if_valid", if_valid, 32'(ev_if));
        chk("mdl_d_valid", d_valid, 32'(ev_d));
        chk("mdl_if_stall", if_stall, 32'(if_req && !ev_if));
        chk("mdl_d_stall", d_stall, 32'(d_req && !ev_d));
        chk("mdl_if_rdata", if_rdata, mem_rdata);
        chk("mdl_d_rdata", d_rdata, mem_rdata);
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!mem_req && n < 20) begin
            cyc();
            n++;
        end
        if (!mem_req) begin
            checks++;
            failures++;
            $display("FAIL mem_req_timeout actual=0 required=1 t=%0t", $time);
        end
    endtask

    logic [31:0] exp_addr [6];

    initial begin
        // reset: registered outputs cleared, stall follows request
        d_req = 1'b1;
        cyc();
        @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_d_valid", d_valid, 0);
        chk("rst_d_stall", d_stall, 1);
        d_req = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();

        // lone fetch, latency 2
        if_req = 1'b1; if_addr = 32'h40;
        @(negedge clk);
        chk("fetch_req_before_edge", mem_req, 0);
        cyc();
        @(negedge clk);
        chk("fetch_mem_req", mem_req, 1);
        chk("fetch_mem_addr", mem_addr, 32'h40);
        chk("fetch_mem_be", mem_be, 4'hF);
        chk("fetch_mem_we", mem_we, 0);
        chk("fetch_stall_n1", if_stall, 1);
        cyc();
        mem_rvalid = 1'b1; mem_rdata = 32'h00500093;
        @(negedge clk);
        chk("fetch_if_valid", if_valid, 1);
        chk("fetch_if_rdata", if_rdata, 32'h00500093);
        chk("fetch_stall_done", if_stall, 0);
        cyc();
        mem_rvalid = 1'b0; if_req = 1'b0;
        @(negedge clk);
        chk("fetch_req_cleared", mem_req, 0);

        // store, latency 3, inputs changed mid-access
        cyc();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_be = 4'h3;
        wait_req();
        @(negedge clk);
        chk("store_we", mem_we, 1);
        chk("store_be", mem_be, 4'h3);
        chk("store_wdata", mem_wdata, 32'hDEADBEEF);
        chk("store_addr", mem_addr, 32'h100);
        cyc();
        d_wdata = 32'h0; d_be = 4'hF;
        @(negedge clk);
        chk("store_hold_wdata", mem_wdata, 32'hDEADBEEF);
        chk("store_hold_be", mem_be, 4'h3);
        cyc();
        mem_rvalid = 1'b1;
        @(negedge clk);
        chk("store_d_valid", d_valid, 1);
        cyc();
        mem_rvalid = 1'b0; d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        chk("store_d_valid_once", d_valid, 0);

        // load, latency 1
        cyc();
        d_req = 1'b1; d_addr = 32'h104; d_be = 4'hF;
        wait_req();
        mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        @(negedge clk);
        chk("load_d_valid", d_valid, 1);
        chk("load_d_rdata", d_rdata, 32'h12345678);
        cyc();
        mem_rvalid = 1'b0; d_req = 1'b0;

        // contention, both requests held high, latency 1
`ifdef ARB_STARVE_GUARD_EN
        exp_addr = '{32'h200, 32'h200, 32'h200, 32'h200, 32'h80, 32'h200};
`else
        exp_addr = '{32'h200, 32'h200, 32'h200, 32'h200, 32'h200, 32'h200};
`endif
        cyc();
        if_req = 1'b1; if_addr = 32'h80; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        for (int g = 0; g < 6; g++) begin
            wait_req();
            chk($sformatf("contend_grant%0d_addr", g), mem_addr, exp_addr[g]);
            mem_rvalid = 1'b1; mem_rdata = 32'(g);
            cyc();
            mem_rvalid = 1'b0;
        end
        if_req = 1'b0; d_req = 1'b0;

        // spurious completion while idle
        cyc();
        mem_rvalid = 1'b1; mem_rdata = 32'hA5A5A5A5;
        @(negedge clk);
        chk("spur_if_valid", if_valid, 0);
        chk("spur_d_valid", d_valid, 0);
        cyc();
        mem_rvalid = 1'b0;
        @(negedge clk);
        chk("spur_mem_req", mem_req, 0);
        cyc();
        d_req = 1'b1; d_addr = 32'h204;
        wait_req();
        chk("spur_next_grant_addr", mem_addr, 32'h204);
        cyc();
        mem_rvalid = 1'b1;
        cyc();
        mem_rvalid = 1'b0; d_req = 1'b0;

        // reset mid-access, late completion ignored
        cyc();
        d_req = 1'b1; d_addr = 32'h300;
        wait_req();
        rst = 1'b1; d_req = 1'b0;
        #1;
        chk("rst_mid_mem_req", mem_req, 0);
        cyc();
        rst = 1'b0;
        cyc();
        mem_rvalid = 1'b1;
        @(negedge clk);
        chk("rst_late_d_valid", d_valid, 0);
        chk("rst_late_if_valid", if_valid, 0);
        cyc();
        mem_rvalid = 1'b0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Shares one single-ported unified instruction/data memory between the IF stage (instruction fetch) and the MEM stage (load/store). Sits between the pipeline's fetch and data-access paths and the external memory port. Data accesses have fixed priority over fetches, with an optional starvation guard. Stall outputs feed the hazard unit to hold the PC and pipeline registers while a requester waits.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte enables are DATA_W/8 bits
- STARVE_MAX, 4, consecutive data grants allowed while a fetch is pending (used only with the guard enabled)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch request; level, held until if_valid
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction, valid when if_valid
- if_valid  out  1  fetch completion pulse
- if_stall  out  1  if_req & ~if_valid
- d_req  in  1  data request; level, held until d_valid
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_be  in  DATA_W/8  store byte enables
- d_rdata  out  DATA_W  load data, valid when d_valid
- d_valid  out  1  data completion pulse (loads and stores)
- d_stall  out  1  d_req & ~d_valid
- mem_req  out  1  memory request, held until mem_rvalid
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_be  out  DATA_W/8  memory byte enables
- mem_rdata  in  DATA_W  memory read data
- mem_rvalid  in  1  one-cycle completion from memory, any latency ≥1 cycle after mem_req rises

## Operation
- States: ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D.
- ARB_IDLE, evaluated at the clock edge:
  - d_req only: go to BUSY_D.
  - if_req only: go to BUSY_I.
  - Both: BUSY_D, except with the guard enabled and starve_cnt == STARVE_MAX, go to BUSY_I.
  - Neither: stay in ARB_IDLE.
- On a grant, mem_addr, mem_we, mem_wdata and mem_be are registered from the granted requester and mem_req is set.
  - Fetch grants register mem_we=0, mem_be=all-ones, mem_wdata=0.
- BUSY_x: mem_req and all mem_* outputs are held stable until mem_rvalid.
  - In the mem_rvalid cycle, x_valid=1 combinationally and x_rdata=mem_rdata.
  - mem_req clears at that edge and the state returns to ARB_IDLE, always.
  - The next grant is therefore decided no earlier than the cycle after completion. This keeps the completing requester's still-high req out of arbitration.
- Outside the mem_rvalid cycle: if_rdata/d_rdata pass mem_rdata unqualified, and both valid outputs are 0.
- mem_rvalid in ARB_IDLE is spurious and is ignored: no valid pulse, no state change.
- Requester inputs change while BUSY are ignored, since the request was latched at grant.

## Timing
- Request seen high at edge N, arbiter idle: mem_req high from cycle N+1.
  - Memory latency L (mem_rvalid in cycle N+L): x_valid in cycle N+L.
  - Next grant possible at edge N+L+1.
- Back-to-back throughput: one access per L+1 cycles.
- Reset values: state ARB_IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, starve_cnt=0. if_valid=d_valid=0 during and after reset; stalls follow req.
- Reset mid-transaction clears mem_req immediately (asynchronous). A later mem_rvalid for the aborted access is ignored.
- Simultaneous requests in ARB_IDLE: data wins unless the guard forces fetch.

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - starve_cnt, width $clog2(STARVE_MAX+1), increments on each data grant made while if_req is high, saturating at STARVE_MAX.
  - Clears on any fetch grant.
  - At STARVE_MAX with both requests pending, fetch is granted.
- ARB_STARVE_GUARD_EN undefined: no counter; strict data-over-fetch priority.

## Structure
- Shared package arb_pkg: arb_state_e enum (ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D) and an arb_src_e requester-id enum (ARB_SRC_IF, ARB_SRC_D).
- One sub-module: arb_starve_ctr (saturating counter with inc/clr/at_max), instantiated only under ARB_STARVE_GUARD_EN.

## Test plan
- **Lone fetch:** if_req=1, if_addr=0x40, L=2, mem_rdata=0x00500093 → mem_req high cycle N+1 with mem_addr=0x40, mem_be=0xF, mem_we=0; if_valid pulses cycle N+2 with if_rdata=0x00500093; if_stall high through N+1.
- **Store:** d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_be=0x3 → mem_we=1, mem_be=0x3, mem_wdata=0xDEADBEEF held until mem_rvalid; d_valid pulses once.
- **Contention, guard off:** if_req and d_req high continuously, STARVE_MAX=4, L=1 → only data grants while d_req stays high; if_stall stays 1.
- **Contention, guard on:** same stimulus → after 4 consecutive data grants the 5th grant goes to fetch; starve_cnt then reads 0.
- **Reset mid-access:** rst asserted while BUSY_D → mem_req=0 in the same cycle; mem_rvalid after rst deasserts produces no d_valid/if_valid.
- **Spurious completion:** mem_rvalid pulse in ARB_IDLE → no valid outputs, state stays ARB_IDLE.
